// File: rtl/serial_neg_pkg.sv
// serial_neg_pkg
// Shared definitions for the bit-serial word negator: the per-word operating
// mode encoding and the beat-counter width helper.
package serial_neg_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_INV  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

   // Beat-counter width for an arbitrary word length; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// serial_neg_lane
// One serial lane of the negator. Holds the seen_one flag used by the
// two's-complement rule and registers the processed bit and overflow flag.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   serial_bit    input bit of the current beat
//   beat_en       a beat is accepted this cycle (valid and not aborted)
//   clear         word discarded; seen_one returns to 0
//   first, last   current beat is beat 0 / beat WIDTH-1 of the word
//   mode          operating mode in effect for this beat
//   out_bit       registered processed bit (0 when no beat)
//   ovf           registered overflow, set only on the last beat in NEG
module serial_neg_lane
   import serial_neg_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  serial_bit,
   input  logic  beat_en,
   input  logic  clear,
   input  logic  first,
   input  logic  last,
   input  mode_t mode,
   output logic  out_bit,
   output logic  ovf
);

   logic seen_one;
   logic seen_eff;
   logic bit_nxt;
   logic ovf_nxt;

   // Beat 0 ignores any history so back-to-back words need no idle cycle.
   assign seen_eff = first ? 1'b0 : seen_one;

   always_comb begin
      bit_nxt = serial_bit;
      ovf_nxt = 1'b0;
      case (mode)
         MODE_NEG: begin
            bit_nxt = serial_bit ^ seen_eff;
            // Only the most negative value (1 then all zeros) has no positive twin.
            ovf_nxt = last & serial_bit & ~seen_eff;
         end
         MODE_INV: bit_nxt = ~serial_bit;
         default:  bit_nxt = serial_bit;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_one <= 1'b0;
         out_bit  <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (clear) begin
            seen_one <= 1'b0;
         end else if (beat_en) begin
            seen_one <= seen_eff | serial_bit;
         end
         out_bit <= beat_en & bit_nxt;
         ovf     <= beat_en & ovf_nxt;
      end
   end

endmodule

// File: rtl/serial_twos_negator.sv
// serial_twos_negator
// Multi-lane, bit-serial, LSB-first word negator with word framing.
// Owns the shared beat counter, the per-word mode register, abort handling
// and the framing output registers; the per-lane datapath lives in
// serial_neg_lane.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   in_valid    a bit beat is present on in_bits
//   in_bits     one serial bit per lane, LSB first
//   mode        word operation, sampled on beat 0 only
//   abort       drop the current beat and restart framing at beat 0
//   out_valid   in_valid delayed one cycle (low for aborted beats)
//   out_bits    processed serial bits
//   out_first   out_bits carries beat 0
//   out_last    out_bits carries beat WIDTH-1
//   ovf         per-lane overflow, meaningful with out_last
module serial_twos_negator
   import serial_neg_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [CHANNELS-1:0] in_bits,
   input  logic [1:0]          mode,
   input  logic                abort,
   output logic                out_valid,
   output logic [CHANNELS-1:0] out_bits,
   output logic                out_first,
   output logic                out_last,
   output logic [CHANNELS-1:0] ovf
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;
   mode_t         mode_q;
   mode_t         mode_eff;
   logic          beat_en;
   logic          first;
   logic          last;

   assign beat_en = in_valid & ~abort;
   assign first   = (cnt == '0);
   assign last    = (cnt == LAST_BEAT);

   // Beat 0 uses the freshly presented mode; later beats use the latched one.
   assign mode_eff = first ? mode_t'(mode) : mode_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (in_valid) begin
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_PASS;
      end else if (beat_en && first) begin
         mode_q <= mode_t'(mode);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= beat_en;
         out_first <= beat_en & first;
         out_last  <= beat_en & last;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      serial_neg_lane u_lane (
         .clk        (clk),
         .reset      (reset),
         .serial_bit (in_bits[g]),
         .beat_en    (beat_en),
         .clear      (abort),
         .first      (first),
         .last       (last),
         .mode       (mode_eff),
         .out_bit    (out_bits[g]),
         .ovf        (ovf[g])
      );
   end

endmodule

// File: tb/tb_serial_twos_negator.sv
// tb_serial_twos_negator
// Directed bench for serial_twos_negator (WIDTH=16, CHANNELS=4). Words are
// driven LSB first on the falling edge; a monitor captures outputs on the
// falling edge into per-lane shift images that are compared against
// hand-computed results.
module tb_serial_twos_negator;

   localparam int W = 16;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [C-1:0] in_bits;
   logic [1:0]   mode;
   logic         abort;
   logic         out_valid;
   logic [C-1:0] out_bits;
   logic         out_first;
   logic         out_last;
   logic [C-1:0] ovf;

   serial_twos_negator #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bits   (in_bits),
      .mode      (mode),
      .abort     (abort),
      .out_valid (out_valid),
      .out_bits  (out_bits),
      .out_first (out_first),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // capture state
   logic [63:0] cap [C];
   logic [63:0] cap_first;
   logic [63:0] cap_last;
   logic [C-1:0] cap_ovf [64];
   int pos;
   int gap_bad;

   always @(negedge clk) begin
      if (out_valid) begin
         if (pos < 64) begin
            for (int l = 0; l < C; l++) cap[l][pos] = out_bits[l];
            cap_first[pos] = out_first;
            cap_last[pos]  = out_last;
            cap_ovf[pos]   = ovf;
         end
         pos++;
      end else if (out_bits != '0 || out_first || out_last || ovf != '0) begin
         gap_bad++;
      end
   end

   task automatic clear_cap();
      @(posedge clk);
      #1;
      for (int l = 0; l < C; l++) cap[l] = '0;
      for (int i = 0; i < 64; i++) cap_ovf[i] = '0;
      cap_first = '0;
      cap_last  = '0;
      pos       = 0;
      gap_bad   = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_bits  = '0;
         abort    = 1'b0;
      end
   endtask

   task automatic send_beat(input logic [C-1:0] b, input logic [1:0] m);
      @(negedge clk);
      in_valid = 1'b1;
      in_bits  = b;
      mode     = m;
      abort    = 1'b0;
   endtask

   function automatic logic [C-1:0] beat_bits(input logic [C-1:0][W-1:0] ops, input int k);
      logic [C-1:0] b;
      for (int l = 0; l < C; l++) b[l] = ops[l][k];
      return b;
   endfunction

   // Beats after beat 0 present a different mode to prove it is ignored.
   task automatic send_word(input logic [C-1:0][W-1:0] ops, input logic [1:0] m,
                            input int g1, input int g2, input int glen);
      for (int k = 0; k < W; k++) begin
         send_beat(beat_bits(ops, k), (k == 0) ? m : 2'(m + 2'd1));
         if (k == g1 || k == g2) idle(glen);
      end
   endtask

   initial begin
      logic [C-1:0][W-1:0] ops;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_bits  = '0;
      mode     = 2'b00;
      abort    = 1'b0;
      pos      = 0;
      gap_bad  = 0;
      #12;
      chk("reset_outputs", {out_valid, out_bits, out_first, out_last, ovf}, '0);
      @(negedge clk);
      reset = 1'b0;

      // NEG on mixed operands, lane 0 = 7668
      clear_cap();
      ops = {16'h0003, 16'h0000, 16'h1234, 16'h7668};
      send_word(ops, 2'b01, -1, -1, 0);
      idle(2);
      chk("neg_7668", cap[0][15:0], 16'h8998);
      chk("neg_1234", cap[1][15:0], 16'hEDCC);
      chk("neg_0000", cap[2][15:0], 16'h0000);
      chk("neg_0003", cap[3][15:0], 16'hFFFD);
      chk("t1_first", cap_first, 64'h1);
      chk("t1_last", cap_last, 64'h8000);
      chk("t1_ovf", cap_ovf[15], 4'b0000);
      chk("t1_count", pos, 16);

      // NEG corner operands
      clear_cap();
      ops = {16'h0001, 16'hFFFF, 16'h0000, 16'h8000};
      send_word(ops, 2'b01, -1, -1, 0);
      idle(2);
      chk("neg_8000", cap[0][15:0], 16'h8000);
      chk("neg_zero", cap[1][15:0], 16'h0000);
      chk("neg_ffff", cap[2][15:0], 16'h0001);
      chk("neg_0001", cap[3][15:0], 16'hFFFF);
      chk("t2_ovf_last", cap_ovf[15], 4'b0001);
      chk("t2_ovf_early", cap_ovf[14], 4'b0000);

      // INV then PASS back-to-back, mid-word mode changes ignored
      clear_cap();
      ops = {16'h0000, 16'h0000, 16'hA5A5, 16'h00FF};
      send_word(ops, 2'b10, -1, -1, 0);
      ops = {16'h0000, 16'h0000, 16'h0F0F, 16'h1234};
      send_word(ops, 2'b00, -1, -1, 0);
      idle(2);
      chk("inv_00ff", cap[0][15:0], 16'hFF00);
      chk("inv_a5a5", cap[1][15:0], 16'h5A5A);
      chk("pass_1234", cap[0][31:16], 16'h1234);
      chk("pass_0f0f", cap[1][31:16], 16'h0F0F);
      chk("t3_first", cap_first, 64'h0001_0001);
      chk("t3_last", cap_last, 64'h8000_8000);
      chk("t3_ovf", {cap_ovf[15], cap_ovf[31]}, 8'h00);
      chk("t3_count", pos, 32);

      // NEG with gaps after beats 2 and 9
      clear_cap();
      ops = {16'h0000, 16'h0000, 16'h0000, 16'h0010};
      send_word(ops, 2'b01, 2, 9, 3);
      idle(2);
      chk("gap_neg_0010", cap[0][15:0], 16'hFFF0);
      chk("gap_first", cap_first, 64'h1);
      chk("gap_last", cap_last, 64'h8000);
      chk("gap_count", pos, 16);
      chk("gap_zero", gap_bad, 0);

      // asynchronous reset while beat 7 is presented
      clear_cap();
      ops = {16'h0006, 16'h0006, 16'h0006, 16'h0006};
      for (int k = 0; k < 7; k++) send_beat(beat_bits(ops, k), 2'b01);
      @(negedge clk);
      in_valid = 1'b1;
      in_bits  = beat_bits(ops, 7);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async", {out_valid, out_bits, out_first, out_last, ovf}, '0);
      @(posedge clk);
      #1;
      chk("rst_held", {out_valid, out_bits, out_first, out_last, ovf}, '0);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      idle(1);
      clear_cap();
      send_word(ops, 2'b01, -1, -1, 0);
      idle(2);
      chk("rst_word", cap[0][15:0], 16'hFFFA);
      chk("rst_word_l3", cap[3][15:0], 16'hFFFA);
      chk("rst_first", cap_first, 64'h1);
      chk("rst_last", cap_last, 64'h8000);

      // abort on beat 5
      clear_cap();
      for (int k = 0; k < 5; k++) send_beat(beat_bits(ops, k), 2'b01);
      @(negedge clk);
      in_valid = 1'b1;
      in_bits  = beat_bits(ops, 5);
      abort    = 1'b1;
      idle(2);
      chk("abort_count", pos, 5);
      chk("abort_zero", gap_bad, 0);
      clear_cap();
      send_word(ops, 2'b01, -1, -1, 0);
      idle(2);
      chk("abort_word", cap[0][15:0], 16'hFFFA);
      chk("abort_first", cap_first, 64'h1);
      chk("abort_last", cap_last, 64'h8000);
      chk("abort_ovf", cap_ovf[15], 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/serial_twos_negator.md
# serial_twos_negator

Multi-channel, bit-serial, LSB-first word negator for streamed operands. It generalises the single-bit serial two's complementer to CHANNELS parallel lanes with a parameterised word length and a per-word operating mode. It adds valid handshaking, word framing and overflow detection. It sits between serial operand sources and the bit-serial adder/multiplier datapath.

## Interface
- WIDTH, 16: bits per word; minimum 2.
- CHANNELS, 4: independent serial lanes sharing framing and mode.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  a bit beat is present on in_bits this cycle.
- in_bits  input  CHANNELS  one serial bit per lane; bit k of a word arrives on beat k (LSB first).
- mode  input  2  word operation; sampled only on the first beat of a word.
- abort  input  1  synchronous; discards the current word; framing restarts at beat 0.
- out_valid  output  1  registered copy of in_valid, with one cycle of latency.
- out_bits  output  CHANNELS  processed serial bits.
- out_first  output  1  out_bits carries beat 0 of a word.
- out_last  output  1  out_bits carries beat WIDTH-1 of a word.
- ovf  output  CHANNELS  per-lane overflow; meaningful only when out_last=1.

## Operation
- Modes (encoding from package):
  - PASS=00: out = in.
  - NEG=01: two's complement.
  - INV=10: ones' complement.
  - 11 is reserved and behaves as PASS.
- Beat counter cnt runs 0..WIDTH-1. It advances only on in_valid and wraps to 0 after WIDTH-1. The first beat after reset, abort or a wrap is beat 0.
- The mode register loads from mode on an in_valid beat with cnt=0 and holds for the whole word. A mode change mid-word is ignored.
- NEG per lane uses a seen_one flag:
  - Output bit = in XOR seen_one_eff, where seen_one_eff = 0 on beat 0, else seen_one.
  - After each beat, seen_one <= seen_one_eff OR in.
- INV: output bit = NOT in. PASS: output bit = in.
- ovf (NEG only), on the last beat: ovf = in AND NOT seen_one_eff, i.e. the input is the most negative value 1 followed by WIDTH-1 zeros. In PASS and INV, ovf = 0.
- A cycle with in_valid=0 is a gap. Counter, seen_one and mode hold. Outputs update with out_valid=0; out_bits, out_first, out_last and ovf are then 0.
- abort has priority over in_valid in the same cycle. That beat is dropped (out_valid=0), cnt goes to 0 and seen_one clears.

## Timing
- Every output is registered. A beat presented at edge n appears on the outputs after edge n+1, so latency is 1 cycle. Throughput is 1 bit per lane per cycle with no stalls.
- Reset values: out_valid=0, out_bits=0, out_first=0, out_last=0, ovf=0, cnt=0, seen_one=0, mode register=PASS.
- Reset asserted mid-word clears immediately (asynchronously). The next valid beat is beat 0 of a new word. No partial output is produced.
- Back-to-back words need no idle cycle. The beat 0 rule forces seen_one_eff=0 regardless of the previous word.
- WIDTH=2 must work: out_first and out_last then occur on alternate valid beats.

## Structure
- Package serial_neg_pkg holds:
  - the mode enum (PASS, NEG, INV, RSVD) as a 2-bit typedef;
  - the localparam for the counter width, $clog2(WIDTH).
- The top level owns cnt, the mode register, abort handling and the out_valid/out_first/out_last registers.
- Sub-module serial_neg_lane, instantiated CHANNELS times via generate:
  - inputs: clk, reset, bit, beat_en, first, last, mode;
  - outputs: registered out_bit and ovf;
  - it holds the seen_one flag.

## Test plan
- NEG, WIDTH=16, lane 0 fed 16'h7668 LSB-first with no gaps → serial output is 16'h8998; out_first on the first output beat; out_last on the 16th; ovf=0.
- NEG on all lanes with operands 16'h8000, 16'h0000, 16'hFFFF and 16'h0001 → outputs 8000, 0000, 0001 and FFFF; ovf = 1, 0, 0, 0 at out_last.
- INV on 16'h00FF, then PASS on 16'h1234 back-to-back with mode changed mid-word → outputs FF00, then 1234. The mode change has no effect until the next beat 0.
- NEG on 16'h0010 with in_valid deasserted for 3 cycles after beats 2 and 9 → output FFF0; out_valid=0 during gaps; counter resumes correctly.
- Reset at beat 7, and separately abort at beat 5 of 16'h0006 followed by a fresh 16'h0006 → all outputs 0 during reset; the next word outputs FFFA with out_first on its first beat.
